cache_nway: RTL and testbench
=============================

CACHE_NWAY -- requirements
Module: cache_nway

Interface
REQ-001 SHALL have parameter S_OFFSET, default 5, byte-offset bits (line = 2**S_OFFSET bytes, 256 bits).
REQ-002 SHALL have parameter S_INDEX, default 3, set-index bits (2**S_INDEX sets).
REQ-003 SHALL have parameter NUM_WAYS, default 4, associativity; legal values 2, 4, 8.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have ports mem_read / mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-007 SHALL have port mem_address  input  32  byte address; bits [S_OFFSET-1:0] ignored.
REQ-008 SHALL have ports mem_wdata  input  256 and mem_byte_enable  input  32  write data, per-byte enables.
REQ-009 SHALL have ports mem_rdata  output  256 and mem_resp  output  1  read line, one-cycle completion pulse.
REQ-010 SHALL have ports pmem_read / pmem_write  output  1 each  memory-side strobes, held until pmem_resp.
REQ-011 SHALL have ports pmem_address  output  32, pmem_wdata  output  256, pmem_rdata  input  256, pmem_resp  input  1.

Function
REQ-012 SHALL hold per way per set: valid, dirty, tag (32-S_OFFSET-S_INDEX bits), 256-bit data; per set: NUM_WAYS-1 tree-PLRU bits.
REQ-013 SHALL implement FSM states IDLE, RESP, WB, FILL.
REQ-014 IDLE, no request: stay IDLE, all strobes low.
REQ-015 IDLE, request with exactly one valid way tag-matching (hit): next state RESP; read latches way data into mem_rdata register; write merges mem_wdata bytes where mem_byte_enable=1 and sets dirty; PLRU points away from hit way; all updates at that edge.
REQ-016 RESP: mem_resp=1 for exactly one cycle, mem_rdata valid that cycle; next state IDLE; hit latency therefore 2 cycles from request assertion.
REQ-017 IDLE miss: victim = lowest-index invalid way, else PLRU-indicated way; victim latched into a register at the transition; next state WB if victim valid and dirty, else FILL.
REQ-018 WB: pmem_write=1, pmem_address={victim tag, index, S_OFFSET zeros}, pmem_wdata=victim data; on pmem_resp clear victim dirty, go FILL.
REQ-019 FILL: pmem_read=1, pmem_address={request tag, index, zeros}; on pmem_resp write pmem_rdata, tag, valid=1, dirty=0 into victim way, go IDLE; re-lookup then hits per REQ-015.
REQ-020 PLRU SHALL update only on hits; fills do not touch PLRU.
REQ-021 mem_read and mem_write both high SHALL be treated as a write.
REQ-022 pmem_resp outside WB/FILL SHALL be ignored; pmem_read and pmem_write SHALL never be high together.
REQ-023 Request changing before mem_resp is illegal; behaviour undefined, no assertion required.

Reset
REQ-024 rst SHALL asynchronously force state IDLE, clear all valid, dirty, PLRU bits and victim register, drive mem_resp, pmem_read, pmem_write to 0 and mem_rdata to 0.
REQ-025 Tag and data arrays SHALL NOT be reset.
REQ-026 rst during WB or FILL SHALL abort the transfer immediately; no partial line installed.

Structure
REQ-027 Package cache_pkg SHALL hold LINE_W=256, MASK_W=32, and the state enum type.
REQ-028 PLRU victim decode and update SHALL live in sub-module cache_plru_tree, parameterised by NUM_WAYS, purely combinational.

Verification (NUM_WAYS=4, S_INDEX=3; address 0x40 = set 2)
REQ-029 After reset read 0x40, pmem_resp 3 cycles after pmem_read with line A -> pmem_read at 0x40, no pmem_write, single mem_resp with mem_rdata=A.
REQ-030 Repeat read 0x40 -> mem_resp 2 cycles after request, zero pmem activity.
REQ-031 Write 0x44 data all 0xFF, enable 0x0000_000F -> mem_resp; read 0x40 returns A with bytes 3:0 = 0xFF, no pmem activity.
REQ-032 Reads 0x140, 0x240, 0x340, then read 0x440 -> pmem_write at 0x40 with merged line, then pmem_read at 0x440; way 0 replaced.
REQ-033 Assert rst mid-FILL -> pmem_read low same cycle; next read 0x440 misses and fills.
REQ-034 NUM_WAYS=2 instance: alternating hits to two tags then third tag -> least-recently-used tag evicted.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and the controller state type for the N-way write-back cache.
package cache_pkg;

    localparam int LINE_W = 256;
    localparam int MASK_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        WB,
        FILL
    } state_t;

endpackage

// File: rtl/cache_plru_tree.sv
// Tree pseudo-LRU: decodes the replacement way and computes the post-hit bit pattern.
module cache_plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         plru_bits,
    input  logic [$clog2(NUM_WAYS)-1:0] hit_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-2:0]         plru_next
);

    localparam int unsigned LEVELS = $clog2(NUM_WAYS);

    // Heap-ordered tree: node n sits at bit n-1, a set bit steers the victim search right.
    always_comb begin
        int unsigned node;
        node = 1;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            node = 2 * node + (plru_bits[node-1] ? 1 : 0);
        end
        victim_way = LEVELS'(node - NUM_WAYS);
    end

    // Every node on the hit way's path is pointed at the opposite subtree.
    always_comb begin
        int unsigned node;
        node      = 0;
        plru_next = plru_bits;
        for (int unsigned l = 0; l < LEVELS; l++) begin
            node = (NUM_WAYS + 32'(hit_way)) >> (LEVELS - l);
            plru_next[node-1] = ~hit_way[LEVELS-1-l];
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back, write-allocate cache with tree-PLRU replacement.
module cache_nway
    import cache_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [31:0]       mem_address,
    input  logic [LINE_W-1:0] mem_wdata,
    input  logic [MASK_W-1:0] mem_byte_enable,
    output logic [LINE_W-1:0] mem_rdata,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int TAG_W = 32 - S_OFFSET - S_INDEX;
    localparam int SETS  = 2 ** S_INDEX;
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic [LINE_W-1:0]   data_arr [SETS][NUM_WAYS];
    logic [TAG_W-1:0]    tag_arr  [SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q  [SETS];
    logic [NUM_WAYS-1:0] dirty_q  [SETS];
    logic [NUM_WAYS-2:0] plru_q   [SETS];

    state_t              state;
    logic [WAY_W-1:0]    victim_q;

    logic [S_INDEX-1:0]  index;
    logic [TAG_W-1:0]    tag;
    logic                req;
    logic [NUM_WAYS-1:0] hit_vec;
    logic                hit;
    logic                has_invalid;
    logic [WAY_W-1:0]    hit_way;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    plru_victim;
    logic [WAY_W-1:0]    miss_victim;
    logic [NUM_WAYS-2:0] plru_next;
    logic [LINE_W-1:0]   merged_line;
    logic                hit_now;
    logic                fill_done;

    assign index = S_INDEX'(mem_address >> S_OFFSET);
    assign tag   = TAG_W'(mem_address >> (S_OFFSET + S_INDEX));
    assign req   = mem_read | mem_write;

    always_comb begin
        hit_vec     = '0;
        hit_way     = '0;
        inv_way     = '0;
        has_invalid = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            hit_vec[w] = valid_q[index][w] && (tag_arr[index][w] == tag);
            if (hit_vec[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!valid_q[index][w] && !has_invalid) begin
                inv_way     = WAY_W'(w);
                has_invalid = 1'b1;
            end
        end
    end

    assign hit         = |hit_vec;
    assign miss_victim = has_invalid ? inv_way : plru_victim;
    assign hit_now     = (state == IDLE) && req && hit;
    assign fill_done   = (state == FILL) && pmem_resp;
    assign pmem_wdata  = data_arr[index][victim_q];

    always_comb begin
        merged_line = data_arr[index][hit_way];
        for (int unsigned b = 0; b < MASK_W; b++) begin
            if (mem_byte_enable[b]) begin
                merged_line[8*b +: 8] = mem_wdata[8*b +: 8];
            end
        end
    end

    cache_plru_tree #(
        .NUM_WAYS(NUM_WAYS)
    ) u_plru (
        .plru_bits (plru_q[index]),
        .hit_way   (hit_way),
        .victim_way(plru_victim),
        .plru_next (plru_next)
    );

    // Line storage carries no reset; valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (hit_now && mem_write) begin
            data_arr[index][hit_way] <= merged_line;
        end
        if (fill_done) begin
            data_arr[index][victim_q] <= pmem_rdata;
            tag_arr[index][victim_q]  <= tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            victim_q     <= '0;
            mem_resp     <= 1'b0;
            mem_rdata    <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (req && hit) begin
                        state         <= RESP;
                        mem_resp      <= 1'b1;
                        plru_q[index] <= plru_next;
                        if (mem_write) begin
                            dirty_q[index][hit_way] <= 1'b1;
                        end else begin
                            mem_rdata <= data_arr[index][hit_way];
                        end
                    end else if (req) begin
                        victim_q <= miss_victim;
                        if (valid_q[index][miss_victim] && dirty_q[index][miss_victim]) begin
                            state        <= WB;
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag_arr[index][miss_victim], index, {S_OFFSET{1'b0}}};
                        end else begin
                            state        <= FILL;
                            pmem_read    <= 1'b1;
                            pmem_address <= {tag, index, {S_OFFSET{1'b0}}};
                        end
                    end
                end
                RESP: begin
                    mem_resp <= 1'b0;
                    state    <= IDLE;
                end
                WB: begin
                    if (pmem_resp) begin
                        dirty_q[index][victim_q] <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_address <= {tag, index, {S_OFFSET{1'b0}}};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (pmem_resp) begin
                        valid_q[index][victim_q] <= 1'b1;
                        dirty_q[index][victim_q] <= 1'b0;
                        pmem_read <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_nway.sv
// Bench for cache_nway: 4-way and 2-way instances against a set/way/PLRU-tree reference model.
module tb_cache_nway;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read        [2];
    logic         mem_write       [2];
    logic [31:0]  mem_address     [2];
    logic [255:0] mem_wdata       [2];
    logic [31:0]  mem_byte_enable [2];
    logic [255:0] mem_rdata       [2];
    logic         mem_resp        [2];
    logic         pmem_read       [2];
    logic         pmem_write      [2];
    logic [31:0]  pmem_address    [2];
    logic [255:0] pmem_wdata      [2];
    logic [255:0] pmem_rdata      [2];
    logic         pmem_resp       [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_nway #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(4)) dut4 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
        .mem_wdata(mem_wdata[0]), .mem_byte_enable(mem_byte_enable[0]),
        .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0]),
        .pmem_read(pmem_read[0]), .pmem_write(pmem_write[0]), .pmem_address(pmem_address[0]),
        .pmem_wdata(pmem_wdata[0]), .pmem_rdata(pmem_rdata[0]), .pmem_resp(pmem_resp[0])
    );

    cache_nway #(.S_OFFSET(5), .S_INDEX(3), .NUM_WAYS(2)) dut2 (
        .clk(clk), .rst(rst),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
        .mem_wdata(mem_wdata[1]), .mem_byte_enable(mem_byte_enable[1]),
        .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1]),
        .pmem_read(pmem_read[1]), .pmem_write(pmem_write[1]), .pmem_address(pmem_address[1]),
        .pmem_wdata(pmem_wdata[1]), .pmem_rdata(pmem_rdata[1]), .pmem_resp(pmem_resp[1])
    );

    // Reference model: plain per-set arrays, PLRU tree walked by halving way ranges.
    int unsigned  ways [2] = '{4, 2};
    bit           m_valid [2][8][4];
    bit           m_dirty [2][8][4];
    logic [23:0]  m_tag   [2][8][4];
    logic [255:0] m_data  [2][8][4];
    bit           m_plru  [2][8][8];
    logic [255:0] ref_mem [bit [32:0]];
    logic [255:0] dev_mem [bit [32:0]];

    bit           busy [2];
    int           cnt  [2];
    int           last_rd_cnt, last_wr_cnt, last_cycles;
    logic [31:0]  last_rd_addr, last_wr_addr;
    logic [255:0] last_wr_data, last_rdata;
    bit           last_both;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] init_line(input int d, input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = {la[23:0], 8'(i + 16 * d)} ^ 32'hC3A5_0F96;
        return l;
    endfunction

    function automatic logic [255:0] ref_get(input int d, input logic [31:0] la);
        if (ref_mem.exists({d[0], la})) return ref_mem[{d[0], la}];
        return init_line(d, la);
    endfunction

    function automatic logic [255:0] dev_get(input int d, input logic [31:0] la);
        if (dev_mem.exists({d[0], la})) return dev_mem[{d[0], la}];
        return init_line(d, la);
    endfunction

    function automatic int model_victim(input int d, input int s);
        int lo = 0, size = int'(ways[d]), node = 1, half;
        while (size > 1) begin
            half = size / 2;
            if (m_plru[d][s][node]) begin lo += half; node = 2 * node + 1; end
            else node = 2 * node;
            size = half;
        end
        return lo;
    endfunction

    function automatic void model_touch(input int d, input int s, input int w);
        int lo = 0, size = int'(ways[d]), node = 1, half;
        while (size > 1) begin
            half = size / 2;
            if (w < lo + half) begin m_plru[d][s][node] = 1'b1; node = 2 * node; end
            else begin m_plru[d][s][node] = 1'b0; lo += half; node = 2 * node + 1; end
            size = half;
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 8; s++) begin
                for (int w = 0; w < 4; w++) begin m_valid[d][s][w] = 0; m_dirty[d][s][w] = 0; end
                for (int n = 0; n < 8; n++) m_plru[d][s][n] = 0;
            end
    endfunction

    task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                                input logic [255:0] wd, input logic [31:0] be,
                                output logic [255:0] e_rdata, output bit e_wb,
                                output logic [31:0] e_wba, output logic [255:0] e_wbd,
                                output bit e_fill, output logic [31:0] e_fa, output bit e_hit);
        int s, w;
        logic [23:0] t;
        s = int'(addr[7:5]);
        t = addr[31:8];
        w = -1;
        for (int i = 0; i < int'(ways[d]); i++)
            if (m_valid[d][s][i] && m_tag[d][s][i] == t) w = i;
        e_hit = (w >= 0); e_wb = 0; e_fill = 0;
        e_wba = '0; e_wbd = '0; e_fa = '0; e_rdata = '0;
        if (!e_hit) begin
            for (int i = int'(ways[d]) - 1; i >= 0; i--) if (!m_valid[d][s][i]) w = i;
            if (w < 0) w = model_victim(d, s);
            if (m_valid[d][s][w] && m_dirty[d][s][w]) begin
                e_wb  = 1;
                e_wba = {m_tag[d][s][w], addr[7:5], 5'b0};
                e_wbd = m_data[d][s][w];
                ref_mem[{d[0], e_wba}] = e_wbd;
            end
            e_fill = 1;
            e_fa   = {addr[31:5], 5'b0};
            m_data[d][s][w]  = ref_get(d, e_fa);
            m_tag[d][s][w]   = t;
            m_valid[d][s][w] = 1;
            m_dirty[d][s][w] = 0;
        end
        model_touch(d, s, w);
        if (wr) begin
            for (int b = 0; b < 32; b++) if (be[b]) m_data[d][s][w][8*b +: 8] = wd[8*b +: 8];
            m_dirty[d][s][w] = 1;
        end else begin
            e_rdata = m_data[d][s][w];
        end
    endtask

    // Memory-side responder, run once per negedge while a request is outstanding.
    task automatic service(input int d, input int lat);
        if (pmem_resp[d]) pmem_resp[d] = 1'b0;
        if (pmem_read[d] && pmem_write[d]) last_both = 1;
        if (pmem_read[d] || pmem_write[d]) begin
            if (!busy[d]) begin
                busy[d] = 1;
                cnt[d]  = lat;
                if (pmem_write[d]) begin
                    last_wr_cnt++;
                    last_wr_addr = pmem_address[d];
                    last_wr_data = pmem_wdata[d];
                    dev_mem[{d[0], pmem_address[d]}] = pmem_wdata[d];
                end else begin
                    last_rd_cnt++;
                    last_rd_addr = pmem_address[d];
                end
            end
            if (cnt[d] == 0) begin
                pmem_resp[d] = 1'b1;
                busy[d] = 0;
                if (!pmem_write[d]) pmem_rdata[d] = dev_get(d, pmem_address[d]);
            end else begin
                cnt[d]--;
            end
        end
    endtask

    task automatic do_req(input int d, input bit wr, input bit rd_too, input logic [31:0] addr,
                          input logic [255:0] wd, input logic [31:0] be, input int lat);
        logic [255:0] e_rdata, e_wbd;
        logic [31:0]  e_wba, e_fa;
        bit           e_wb, e_fill, e_hit, done;
        int           n;
        model_access(d, wr, addr, wd, be, e_rdata, e_wb, e_wba, e_wbd, e_fill, e_fa, e_hit);
        last_rd_cnt = 0; last_wr_cnt = 0; last_both = 0; busy[d] = 0;
        mem_address[d] = addr; mem_wdata[d] = wd; mem_byte_enable[d] = be;
        mem_read[d] = wr ? rd_too : 1'b1;
        mem_write[d] = wr;
        n = 0; done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            service(d, lat);
            if (mem_resp[d]) begin done = 1; last_rdata = mem_rdata[d]; end
        end
        mem_read[d] = 1'b0; mem_write[d] = 1'b0; pmem_resp[d] = 1'b0;
        last_cycles = n + 1;
        chk("resp_seen", 256'(done), 256'(1));
        chk("wb_count", 256'(last_wr_cnt), 256'(e_wb));
        chk("fill_count", 256'(last_rd_cnt), 256'(e_fill));
        chk("pmem_exclusive", 256'(last_both), 256'(0));
        if (e_wb) begin
            chk("wb_addr", 256'(last_wr_addr), 256'(e_wba));
            chk("wb_data", last_wr_data, e_wbd);
        end
        if (e_fill) chk("fill_addr", 256'(last_rd_addr), 256'(e_fa));
        if (!wr) chk("rdata", last_rdata, e_rdata);
        if (e_hit) chk("hit_latency", 256'(last_cycles), 256'(2));
        @(negedge clk);
        chk("resp_pulse", 256'(mem_resp[d]), 256'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mem_read[d] = 0; mem_write[d] = 0; mem_address[d] = '0;
            mem_wdata[d] = '0; mem_byte_enable[d] = '0;
            pmem_resp[d] = 0; pmem_rdata[d] = '0; busy[d] = 0; cnt[d] = 0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_resp", 256'(mem_resp[d]), 256'(0));
            chk("rst_pmem_read", 256'(pmem_read[d]), 256'(0));
            chk("rst_pmem_write", 256'(pmem_write[d]), 256'(0));
            chk("rst_mem_rdata", mem_rdata[d], '0);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [255:0] line_a, merged_a, wd;
        logic [31:0]  addr;
        int           n, d;
        bit           wr;

        do_reset();
        line_a = init_line(0, 32'h40);

        // Cold read miss then repeat hit
        do_req(0, 0, 0, 32'h40, '0, '0, 3);
        chk("cold_rd_addr", 256'(last_rd_addr), 256'(32'h40));
        chk("cold_rdata", last_rdata, line_a);
        do_req(0, 0, 0, 32'h40, '0, '0, 3);
        chk("hit_no_fill", 256'(last_rd_cnt + last_wr_cnt), 256'(0));

        // Partial write then read back
        do_req(0, 1, 0, 32'h44, '1, 32'h0000_000F, 1);
        merged_a = line_a;
        merged_a[31:0] = 32'hFFFF_FFFF;
        do_req(0, 0, 0, 32'h40, '0, '0, 1);
        chk("merged_rdata", last_rdata, merged_a);

        // Fill remaining ways, then evict the dirty way 0
        do_req(0, 0, 0, 32'h140, '0, '0, 2);
        do_req(0, 0, 0, 32'h240, '0, '0, 0);
        do_req(0, 0, 0, 32'h340, '0, '0, 1);
        do_req(0, 0, 0, 32'h440, '0, '0, 2);
        chk("evict_wb_addr", 256'(last_wr_addr), 256'(32'h40));
        chk("evict_wb_data", last_wr_data, merged_a);
        chk("evict_fill_addr", 256'(last_rd_addr), 256'(32'h440));

        // Reset in the middle of a fill
        mem_address[0] = 32'h540; mem_read[0] = 1'b1;
        n = 0;
        while (!pmem_read[0] && n < 20) begin @(negedge clk); n++; end
        chk("abort_fill_started", 256'(pmem_read[0]), 256'(1));
        #2 rst = 1'b1;
        #1 chk("abort_pmem_read", 256'(pmem_read[0]), 256'(0));
        mem_read[0] = 1'b0;
        model_reset();
        busy[0] = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_req(0, 0, 0, 32'h440, '0, '0, 2);
        chk("post_abort_fill", 256'(last_rd_cnt), 256'(1));

        // Two-way LRU: A B A B A, then C must evict B
        do_req(1, 0, 0, 32'h80, '0, '0, 1);
        do_req(1, 0, 0, 32'h180, '0, '0, 1);
        do_req(1, 0, 0, 32'h80, '0, '0, 1);
        do_req(1, 0, 0, 32'h180, '0, '0, 1);
        do_req(1, 0, 0, 32'h80, '0, '0, 1);
        do_req(1, 0, 0, 32'h280, '0, '0, 1);
        do_req(1, 0, 0, 32'h80, '0, '0, 1);
        chk("lru_keep_a", 256'(last_rd_cnt), 256'(0));
        do_req(1, 0, 0, 32'h180, '0, '0, 1);
        chk("lru_evicted_b", 256'(last_rd_cnt), 256'(1));

        // Randomized traffic on both instances
        for (int i = 0; i < 240; i++) begin
            d  = (i % 3 == 2) ? 1 : 0;
            wr = ($urandom_range(0, 9) < 4);
            addr = (32'($urandom_range(0, d ? 2 : 5)) << 8) | (32'($urandom_range(0, 7)) << 5)
                 | 32'($urandom_range(0, 31));
            for (int k = 0; k < 8; k++) wd[32*k +: 32] = $urandom();
            do_req(d, wr, 1'($urandom_range(0, 1)), addr, wd, $urandom(), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
